// File: rtl/perceptron_pkg.sv
// Shared sizing constants and FSM state encoding for the perceptron core.
package perceptron_pkg;

    localparam int N_FEAT = 4;
    localparam int XW     = 4;
    localparam int WW     = 8;
    localparam int AW     = 16;

    typedef enum logic [2:0] {
        LOAD,
        MAC,
        DECIDE,
        UPDATE,
        OUT
    } state_t;

endpackage

// File: rtl/perceptron_if.sv
// Feature-in / result-out handshake bundle between a sample source and the core.
interface perceptron_if #(
    parameter int XW = perceptron_pkg::XW,
    parameter int AW = perceptron_pkg::AW
);

    logic                 feat_valid;
    logic                 feat_ready;
    logic signed [XW-1:0] feat_data;
    logic                 train;
    logic                 label;
    logic                 clear_w;
    logic                 y_valid;
    logic                 y_ready;
    logic                 y;
    logic signed [AW-1:0] acc_out;
    logic                 updated;

    modport master (
        output feat_valid, feat_data, train, label, clear_w, y_ready,
        input  feat_ready, y_valid, y, acc_out, updated
    );

    modport slave (
        input  feat_valid, feat_data, train, label, clear_w, y_ready,
        output feat_ready, y_valid, y, acc_out, updated
    );

endinterface

// File: rtl/perceptron_sat_add.sv
// Signed W-bit adder that clamps to the representable range instead of wrapping.
module perceptron_sat_add
    import perceptron_pkg::*;
#(
    parameter int W = WW
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_sum
);

    logic signed [W:0] w_full;
    logic              w_ovf;

    assign w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};
    // The two top bits disagree exactly when the true sum left the W-bit range
    assign w_ovf  = w_full[W] ^ w_full[W-1];

    always_comb begin
        o_sum = w_full[W-1:0];
        if (w_ovf) begin
            o_sum = w_full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/perceptron_core.sv
// Sequential perceptron: buffers a feature vector, runs one multiply-accumulate
// per cycle, classifies, and optionally applies the perceptron learning rule.
module perceptron_core
    import perceptron_pkg::*;
#(
    parameter int N_FEAT = perceptron_pkg::N_FEAT,
    parameter int XW     = perceptron_pkg::XW,
    parameter int WW     = perceptron_pkg::WW,
    parameter int AW     = perceptron_pkg::AW
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    perceptron_if.slave bus
);

    localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int PW = WW + XW;
    typedef logic [IW-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(N_FEAT - 1);

    state_t               r_state;
    state_t               w_nextState;
    idx_t                 r_idx;
    logic                 r_live;
    logic signed [XW-1:0] r_x [N_FEAT];
    logic signed [WW-1:0] r_w [N_FEAT];
    logic signed [WW-1:0] r_bias;
    logic signed [AW-1:0] r_acc;
    logic                 r_train;
    logic                 r_label;
    logic                 r_y;
    logic                 r_updated;

    logic                 w_featHs;
    logic                 w_lastFeat;
    logic                 w_clear;
    logic                 w_yDecide;
    logic signed [PW-1:0] w_wSel;
    logic signed [PW-1:0] w_xSel;
    logic signed [PW-1:0] w_prod;
    logic signed [WW-1:0] w_wNext [N_FEAT];
    logic signed [WW-1:0] w_biasNext;
    logic signed [WW-1:0] w_biasDelta;

    // r_live keeps feat_ready low while reset is asserted and until the first edge after it
    assign bus.feat_ready = ena & r_live & (r_state == LOAD);
    assign bus.y_valid    = (r_state == OUT);
    assign bus.y          = r_y;
    assign bus.acc_out    = r_acc;
    assign bus.updated    = r_updated;

    assign w_featHs   = bus.feat_valid & bus.feat_ready;
    assign w_lastFeat = (r_idx == LAST_IDX);
    assign w_clear    = ena & bus.clear_w & (r_state == LOAD) & (r_idx == '0) & ~w_featHs;
    assign w_yDecide  = ~r_acc[AW-1];

    assign w_wSel      = {{XW{r_w[r_idx][WW-1]}}, r_w[r_idx]};
    assign w_xSel      = {{WW{r_x[r_idx][XW-1]}}, r_x[r_idx]};
    assign w_prod      = w_wSel * w_xSel;
    assign w_biasDelta = r_label ? WW'(1) : {WW{1'b1}};

    for (genvar g = 0; g < N_FEAT; g++) begin : g_wAdd
        logic signed [WW-1:0] w_xExt;
        logic signed [WW-1:0] w_delta;

        assign w_xExt  = {{(WW-XW){r_x[g][XW-1]}}, r_x[g]};
        assign w_delta = r_label ? w_xExt : -w_xExt;

        perceptron_sat_add #(.W(WW)) u_wAdd (
            .i_a   (r_w[g]),
            .i_b   (w_delta),
            .o_sum (w_wNext[g])
        );
    end

    perceptron_sat_add #(.W(WW)) u_biasAdd (
        .i_a   (r_bias),
        .i_b   (w_biasDelta),
        .o_sum (w_biasNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else if (ena) begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            LOAD:    if (w_featHs && w_lastFeat) w_nextState = MAC;
            MAC:     if (w_lastFeat) w_nextState = DECIDE;
            DECIDE:  w_nextState = (r_train && (w_yDecide != r_label)) ? UPDATE : OUT;
            UPDATE:  w_nextState = OUT;
            OUT:     if (bus.y_ready) w_nextState = LOAD;
            default: w_nextState = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_live    <= 1'b0;
            r_bias    <= '0;
            r_acc     <= '0;
            r_train   <= 1'b0;
            r_label   <= 1'b0;
            r_y       <= 1'b0;
            r_updated <= 1'b0;
            for (int i = 0; i < N_FEAT; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
        end else if (ena) begin
            r_live <= 1'b1;
            case (r_state)
                LOAD: begin
                    if (w_featHs) begin
                        r_x[r_idx] <= bus.feat_data;
                        if (w_lastFeat) begin
                            r_idx     <= '0;
                            r_train   <= bus.train;
                            r_label   <= bus.label;
                            r_acc     <= {{(AW-WW){r_bias[WW-1]}}, r_bias};
                            r_updated <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else if (w_clear) begin
                        r_bias <= '0;
                        for (int i = 0; i < N_FEAT; i++) begin
                            r_w[i] <= '0;
                        end
                    end
                end
                MAC: begin
                    r_acc <= r_acc + {{(AW-PW){w_prod[PW-1]}}, w_prod};
                    r_idx <= w_lastFeat ? '0 : r_idx + 1'b1;
                end
                DECIDE: r_y <= w_yDecide;
                UPDATE: begin
                    r_bias    <= w_biasNext;
                    r_updated <= 1'b1;
                    for (int i = 0; i < N_FEAT; i++) begin
                        r_w[i] <= w_wNext[i];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_core.sv
// Scoreboard bench for perceptron_core: a reference perceptron predicts each
// result when the sample is driven; results are popped when y_valid appears.
module tb_perceptron_core;
    import perceptron_pkg::*;

    typedef struct {
        int acc;
        int y;
        int upd;
        int lat;
        int stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    perceptron_if #(.XW(XW), .AW(AW)) bus ();

    perceptron_core #(
        .N_FEAT (N_FEAT),
        .XW     (XW),
        .WW     (WW),
        .AW     (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   nChecks = 0;
    int   nPassed = 0;
    exp_t sb[$];
    int   mW[N_FEAT];
    int   mB;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        if (observed == expected) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int sat(input int v);
        int hi;
        int lo;
        hi = (1 << (WW - 1)) - 1;
        lo = -(1 << (WW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic void modelClear();
        mB = 0;
        for (int i = 0; i < N_FEAT; i++) mW[i] = 0;
    endfunction

    // Latency counts edges after the last-feature handshake edge: cycle T+6 is 5 edges later
    function automatic void modelSample(input int xs[N_FEAT], input bit train, input bit label,
                                        input int stall);
        exp_t e;
        int   acc;
        acc = mB;
        for (int i = 0; i < N_FEAT; i++) acc += mW[i] * xs[i];
        e.acc   = acc;
        e.y     = (acc >= 0) ? 1 : 0;
        e.upd   = (train && (e.y != int'(label))) ? 1 : 0;
        if (e.upd != 0) begin
            for (int i = 0; i < N_FEAT; i++) mW[i] = sat(mW[i] + (label ? xs[i] : -xs[i]));
            mB = sat(mB + (label ? 1 : -1));
        end
        e.stall = stall;
        e.lat   = ((e.upd != 0) ? 6 : 5) + stall;
        sb.push_back(e);
    endfunction

    task automatic applyStimulus(input int xs[N_FEAT], input bit train, input bit label,
                                 input int stall, input int clearIdx, input bit clearHs);
        int n;
        for (int i = 0; i < N_FEAT; i++) begin
            if (clearIdx == i && !clearHs) begin
                bus.clear_w    = 1'b1;
                bus.feat_valid = 1'b0;
                @(posedge clk); #1;
                bus.clear_w = 1'b0;
                if (i == 0) modelClear();
            end
            bus.feat_valid = 1'b1;
            bus.feat_data  = XW'(xs[i]);
            bus.train      = train;
            bus.label      = label;
            bus.clear_w    = (clearIdx == i && clearHs);
            n = 0;
            while (!bus.feat_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!bus.feat_ready) checkOutput("feat_ready_timeout", bus.feat_ready, 1);
            @(posedge clk); #1;
            bus.feat_valid = 1'b0;
            bus.clear_w    = 1'b0;
        end
        modelSample(xs, train, label, stall);
    endtask

    task automatic waitResult(input int hold);
        exp_t e;
        int   k;
        e = sb.pop_front();
        k = 0;
        while (!bus.y_valid && k < 100) begin
            if (e.stall > 0 && k == 2) ena = 1'b0;
            if (e.stall > 0 && k == 2 + e.stall) ena = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        ena = 1'b1;
        checkOutput("y_valid", bus.y_valid, 1);
        checkOutput("latency", k, e.lat);
        checkOutput("acc_out", bus.acc_out, e.acc);
        checkOutput("y", bus.y, e.y);
        checkOutput("updated", bus.updated, e.upd);
        checkOutput("ready_in_out", bus.feat_ready, 0);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            checkOutput("hold_y_valid", bus.y_valid, 1);
            checkOutput("hold_acc_out", bus.acc_out, e.acc);
            checkOutput("hold_y", bus.y, e.y);
            checkOutput("hold_ready", bus.feat_ready, 0);
        end
        bus.y_ready = 1'b1;
        @(posedge clk); #1;
        bus.y_ready = 1'b0;
        checkOutput("y_valid_drop", bus.y_valid, 0);
        checkOutput("ready_after_out", bus.feat_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int xv[N_FEAT];
        rst_n          = 1'b0;
        ena            = 1'b1;
        bus.feat_valid = 1'b0;
        bus.feat_data  = '0;
        bus.train      = 1'b0;
        bus.label      = 1'b0;
        bus.clear_w    = 1'b0;
        bus.y_ready    = 1'b0;
        modelClear();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_y_valid", bus.y_valid, 0);
        checkOutput("rst_y", bus.y, 0);
        checkOutput("rst_acc_out", bus.acc_out, 0);
        checkOutput("rst_updated", bus.updated, 0);
        checkOutput("rst_feat_ready", bus.feat_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", bus.feat_ready, 1);

        xv = '{1, 2, 3, 4};
        applyStimulus(xv, 1'b0, 1'b0, 0, -1, 1'b0); waitResult(0);
        applyStimulus(xv, 1'b1, 1'b0, 0, -1, 1'b0); waitResult(0);
        applyStimulus(xv, 1'b0, 1'b0, 0, -1, 1'b0); waitResult(10);
        applyStimulus(xv, 1'b0, 1'b0, 5, -1, 1'b0); waitResult(0);

        // clear_w at idx 2 and clear_w alongside a handshake are both ignored; idx 0 idle clears
        applyStimulus(xv, 1'b0, 1'b0, 0, 2, 1'b0); waitResult(0);
        applyStimulus(xv, 1'b0, 1'b0, 0, 0, 1'b1); waitResult(0);
        applyStimulus(xv, 1'b0, 1'b0, 0, 0, 1'b0); waitResult(0);

        applyStimulus(xv, 1'b1, 1'b0, 0, -1, 1'b0); waitResult(0);
        xv = '{3, -2, 7, -8};
        applyStimulus(xv, 1'b1, 1'b1, 0, -1, 1'b0); waitResult(0);

        // Abandon a sample mid-MAC with an asynchronous reset
        xv = '{1, 2, 3, 4};
        applyStimulus(xv, 1'b0, 1'b0, 0, -1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_y_valid", bus.y_valid, 0);
        checkOutput("mid_rst_y", bus.y, 0);
        checkOutput("mid_rst_acc_out", bus.acc_out, 0);
        checkOutput("mid_rst_updated", bus.updated, 0);
        checkOutput("mid_rst_feat_ready", bus.feat_ready, 0);
        sb.delete();
        modelClear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(xv, 1'b0, 1'b0, 0, -1, 1'b0); waitResult(0);

        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < N_FEAT; i++) xv[i] = int'($urandom_range(0, 15)) - 8;
            applyStimulus(xv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          (s % 7 == 3) ? 5 : 0, -1, 1'b0);
            waitResult(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/perceptron_core.md
PERCEPTRON_CORE -- requirements
Module: perceptron_core

Interface
REQ-001 SHALL have parameters: N_FEAT=4 (features per sample), XW=4 (signed feature width), WW=8 (signed weight/bias width), AW=16 (signed accumulator width).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port ena  in  1  enable; low freezes all state.
REQ-004 SHALL have port feat_valid  in  1  feature word offered.
REQ-005 SHALL have port feat_ready  out  1  core accepts a feature.
REQ-006 SHALL have port feat_data  in  XW  signed feature value.
REQ-007 SHALL have port train  in  1  sample is a training sample; sampled with the last feature.
REQ-008 SHALL have port label  in  1  target class; sampled with the last feature.
REQ-009 SHALL have port clear_w  in  1  zero all weights and bias.
REQ-010 SHALL have port y_valid  out  1  result available.
REQ-011 SHALL have port y_ready  in  1  consumer takes the result.
REQ-012 SHALL have port y  out  1  predicted class.
REQ-013 SHALL have port acc_out  out  AW  signed pre-activation sum.
REQ-014 SHALL have port updated  out  1  weights changed for this sample.

Function
REQ-015 SHALL implement states LOAD, MAC, DECIDE, UPDATE, OUT.
REQ-016 LOAD: feat_ready=ena; each handshake (feat_valid & feat_ready) stores feat_data at index idx and increments idx.
REQ-017 The handshake at idx=N_FEAT-1 SHALL latch train/label, set acc to sign-extended bias, reset the MAC index, and enter MAC.
REQ-018 MAC SHALL last N_FEAT cycles, one term per cycle in index order: acc += sign-extended w[i]*x[i] (12-bit product); no overflow is possible at these widths.
REQ-019 DECIDE SHALL last 1 cycle: y = (acc >= 0); next state UPDATE if train and y != label, else OUT.
REQ-020 UPDATE SHALL last 1 cycle: all w[i] += (label ? +x[i] : -x[i]) in parallel; bias += (label ? +1 : -1); every result saturates to [-128,127].
REQ-021 OUT: y_valid=1; y, acc_out and updated remain stable until y_ready; the handshake returns to LOAD with idx=0.
REQ-022 Latency from the last-feature handshake at cycle T: y_valid SHALL rise at T+6 without update and at T+7 with update.
REQ-023 updated SHALL be 1 only if UPDATE ran for the current sample.
REQ-024 feat_ready SHALL be 0 outside LOAD; y_valid SHALL be 0 outside OUT.
REQ-025 clear_w SHALL act only in LOAD with idx=0 and no simultaneous feature handshake; otherwise it is ignored.
REQ-026 A clear_w coinciding with a feature handshake SHALL be ignored and the feature SHALL be accepted.
REQ-027 With ena=0: no register changes, feat_ready=0, and y_valid/y/acc_out hold their values.
REQ-028 With ena=0, no handshake SHALL complete.

Reset
REQ-029 rst_n low SHALL immediately force: state=LOAD, idx=0, weights=0, bias=0, acc=0.
REQ-030 rst_n low SHALL immediately force: y_valid=0, y=0, acc_out=0, updated=0, feat_ready=0.
REQ-031 After rst_n deasserts, feat_ready SHALL rise on the first clock edge (given ena=1).
REQ-032 Reset mid-operation SHALL abandon the sample; learned weights are lost.

Structure
REQ-033 Package perceptron_pkg SHALL hold N_FEAT, XW, WW, AW and the state enumeration.
REQ-034 Sub-module perceptron_sat_add SHALL implement the saturating signed WW-bit add; one instance per weight plus one for bias.

Verification
REQ-035 Reset, inference of x=(1,2,3,4) with train=0 -> y_valid at T+6, acc_out=0, y=1, updated=0.
REQ-036 From reset, train x=(1,2,3,4) with label=0 -> y_valid at T+7, y=1, updated=1; re-infer the same x -> acc_out=-31, y=0, updated=0.
REQ-037 Hold y_ready=0 for 10 cycles in OUT -> y_valid, y and acc_out stable, feat_ready=0; the y_ready pulse returns to LOAD.
REQ-038 Drop ena for 5 cycles during MAC -> result and latency identical to the uninterrupted case shifted by 5 cycles.
REQ-039 Assert rst_n low during MAC after training -> outputs zero; re-infer x=(1,2,3,4) -> acc_out=0.
REQ-040 Train to nonzero weights, then clear_w in LOAD with idx=0 -> next inference acc_out=0; clear_w with idx=2 -> ignored.
